// File: rtl/nn_input_feeder.sv
// Input-vector buffer feeding the 2x2 nn array with a one-cycle column skew and start pulse.
// Optional build macro FEEDER_REPLAY_EN: keep the batch after a stream so later go pulses replay it.
//
// state  | meaning
// IDLE   | accept host writes, wait for go/clear
// STREAM | issue one stored entry per cycle on column 1
// DRAIN  | column 2 emits the last entry, then done and back to IDLE
module nn_input_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  input  logic [DATA_WIDTH-1:0] wr_data_2,
  input  logic                  go,
  input  logic                  clear,
  output logic                  feed_start,
  output logic [DATA_WIDTH-1:0] feed_data_1,
  output logic                  feed_valid_1,
  output logic [DATA_WIDTH-1:0] feed_data_2,
  output logic                  feed_valid_2,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     rd_ptr, rd_ptr_nxt;
  logic [ADDR_WIDTH:0]     count_nxt;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    issue;
  logic                    start_nxt;
  logic                    done_nxt;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   col2_stage;

  logic [DATA_WIDTH-1:0]   mem_1 [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_2 [DEPTH];

  assign wr_ready = (state == IDLE) & (count < DEPTH_C) & ~go & ~clear;
  assign wr_fire  = wr_valid & wr_ready;
  assign busy     = (state != IDLE);
  // The first entry is issued on the same edge that leaves IDLE, so read index 0 there.
  assign rd_idx   = (state == IDLE) ? '0 : rd_ptr[ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    issue      = 1'b0;
    start_nxt  = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (count != '0) begin
            issue      = 1'b1;
            start_nxt  = 1'b1;
            rd_ptr_nxt = ONE_C;
            state_nxt  = STREAM;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (clear) begin
          count_nxt = '0;
        end else if (wr_fire) begin
          count_nxt = count + ONE_C;
        end
      end
      STREAM: begin
        if (rd_ptr < count) begin
          issue      = 1'b1;
          rd_ptr_nxt = rd_ptr + ONE_C;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
`ifndef FEEDER_REPLAY_EN
        count_nxt = '0;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Buffer contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_1[count[ADDR_WIDTH-1:0]] <= wr_data_1;
      mem_2[count[ADDR_WIDTH-1:0]] <= wr_data_2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      feed_start   <= 1'b0;
      feed_valid_1 <= 1'b0;
      feed_data_1  <= '0;
      col2_stage   <= '0;
      feed_valid_2 <= 1'b0;
      feed_data_2  <= '0;
      done         <= 1'b0;
    end else begin
      feed_start   <= start_nxt;
      feed_valid_1 <= issue;
      feed_data_1  <= issue ? mem_1[rd_idx] : '0;
      col2_stage   <= issue ? mem_2[rd_idx] : '0;
      feed_valid_2 <= feed_valid_1;
      feed_data_2  <= feed_valid_1 ? col2_stage : '0;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_nn_input_feeder.sv
// Randomized self-checking bench for nn_input_feeder against a queue-based stream model.
// Builds with or without FEEDER_REPLAY_EN; expectations follow the same macro.
module tb_nn_input_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data_1 = '0;
  logic [15:0] wr_data_2 = '0;
  logic        go = 1'b0;
  logic        clear = 1'b0;
  logic        feed_start;
  logic [15:0] feed_data_1;
  logic        feed_valid_1;
  logic [15:0] feed_data_2;
  logic        feed_valid_2;
  logic        busy;
  logic        done;
  logic [3:0]  count;

  int total = 0;
  int bad = 0;

  logic [15:0] q1[$];
  logic [15:0] q2[$];

  logic [36:0] obs;
  assign obs = {feed_start, feed_valid_1, feed_data_1, feed_valid_2, feed_data_2, busy, done};

  nn_input_feeder #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data_1(wr_data_1), .wr_data_2(wr_data_2), .go(go), .clear(clear),
    .feed_start(feed_start), .feed_data_1(feed_data_1), .feed_valid_1(feed_valid_1),
    .feed_data_2(feed_data_2), .feed_valid_2(feed_valid_2), .busy(busy),
    .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected observation k cycles after the edge that sampled go, for a batch of n entries.
  function automatic logic [36:0] exp_vec(int k, int n);
    logic s, v1, v2, b, dn;
    logic [15:0] d1, d2;
    s  = (k == 0) && (n > 0);
    v1 = k < n;
    d1 = v1 ? q1[k] : 16'd0;
    v2 = (k >= 1) && (k <= n);
    d2 = v2 ? q2[k-1] : 16'd0;
    b  = (n > 0) && (k <= n);
    dn = (n == 0) ? (k == 0) : (k == n + 1);
    return {s, v1, d1, v2, d2, b, dn};
  endfunction

  task automatic do_write(logic [15:0] a, logic [15:0] b);
    wr_valid = 1'b1; wr_data_1 = a; wr_data_2 = b;
    if (q1.size() < 8) begin q1.push_back(a); q2.push_back(b); end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q1.delete(); q2.delete();
  endtask

  task automatic after_done();
`ifndef FEEDER_REPLAY_EN
    q1.delete(); q2.delete();
`endif
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({obs, count, wr_ready} !== {37'd0, 4'd0, 1'b1}) begin
      bad++; $display("FAIL reset_outputs got %h expected %h", {obs, count, wr_ready}, {37'd0, 4'd0, 1'b1});
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    do_write(16'd3, -16'sd4); do_write(16'd5, 16'd6); do_write(16'd7, -16'sd8);
    n = q1.size();
    total++;
    if (count !== 4'd3) begin bad++; $display("FAIL basic_count got %0d expected 3", count); end
    go = 1'b1; tick(); go = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      total++;
      if (obs !== exp_vec(k, n)) begin bad++; $display("FAIL basic k=%0d got %h expected %h", k, obs, exp_vec(k, n)); end
      tick();
    end
    after_done();
    total++;
    if (count !== 4'(q1.size())) begin bad++; $display("FAIL basic_count_after got %0d expected %0d", count, q1.size()); end
    do_clear();
  endtask

  task automatic test_full();
    int n;
    for (int i = 0; i < 8; i++) do_write(16'($urandom), 16'($urandom));
    n = q1.size();
    wr_valid = 1'b1; wr_data_1 = 16'hdead; wr_data_2 = 16'hbeef;
    #1;
    total++;
    if ({count, wr_ready} !== {4'd8, 1'b0}) begin bad++; $display("FAIL full_ready got count=%0d ready=%b expected count=8 ready=0", count, wr_ready); end
    tick(); wr_valid = 1'b0;
    total++;
    if (count !== 4'd8) begin bad++; $display("FAIL full_ninth got %0d expected 8", count); end
    go = 1'b1; tick(); go = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      total++;
      if (obs !== exp_vec(k, n)) begin bad++; $display("FAIL full k=%0d got %h expected %h", k, obs, exp_vec(k, n)); end
      tick();
    end
    after_done();
    do_clear();
  endtask

  task automatic test_go_empty();
    go = 1'b1; tick(); go = 1'b0;
    for (int k = 0; k <= 1; k++) begin
      total++;
      if ({obs, count} !== {exp_vec(k, 0), 4'd0}) begin bad++; $display("FAIL go_empty k=%0d got %h expected %h", k, {obs, count}, {exp_vec(k, 0), 4'd0}); end
      tick();
    end
  endtask

  task automatic test_go_with_write();
    int n;
    do_write(16'h1111, 16'h2222); do_write(16'h3333, 16'h4444);
    n = q1.size();
    go = 1'b1; wr_valid = 1'b1; wr_data_1 = 16'h5555; wr_data_2 = 16'h6666;
    #1;
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL go_write_ready got %b expected 0", wr_ready); end
    tick(); go = 1'b0; wr_valid = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      total++;
      if (obs !== exp_vec(k, n)) begin bad++; $display("FAIL go_write k=%0d got %h expected %h", k, obs, exp_vec(k, n)); end
      tick();
    end
    after_done();
    do_clear();
  endtask

  task automatic test_reset_mid();
    int n;
    do_write(16'd10, 16'd20); do_write(16'd30, 16'd40); do_write(16'd50, 16'd60);
    go = 1'b1; tick(); go = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({obs, count} !== 41'd0) begin bad++; $display("FAIL reset_mid got %h expected 0", {obs, count}); end
    q1.delete(); q2.delete();
    #2 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if ({done, busy} !== 2'b00) begin bad++; $display("FAIL reset_mid_done k=%0d got %b expected 00", k, {done, busy}); end
    end
    do_write(-16'sd1, 16'd2); do_write(16'd3, -16'sd4);
    n = q1.size();
    go = 1'b1; tick(); go = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      total++;
      if (obs !== exp_vec(k, n)) begin bad++; $display("FAIL reset_mid_restart k=%0d got %h expected %h", k, obs, exp_vec(k, n)); end
      tick();
    end
    after_done();
    do_clear();
  endtask

  task automatic test_replay();
    int n;
    do_write(16'd1, 16'd2); do_write(16'd3, 16'd4);
    n = q1.size();
    go = 1'b1; tick(); go = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      total++;
      if (obs !== exp_vec(k, n)) begin bad++; $display("FAIL replay_first k=%0d got %h expected %h", k, obs, exp_vec(k, n)); end
      tick();
    end
    after_done();
    n = q1.size();
    total++;
    if (count !== 4'(n)) begin bad++; $display("FAIL replay_count got %0d expected %0d", count, n); end
    go = 1'b1; tick(); go = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      total++;
      if (obs !== exp_vec(k, n)) begin bad++; $display("FAIL replay_second k=%0d got %h expected %h", k, obs, exp_vec(k, n)); end
      tick();
    end
    after_done();
    do_clear();
    total++;
    if (count !== 4'd0) begin bad++; $display("FAIL replay_clear got %0d expected 0", count); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 10; it++) begin
      do_clear();
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        do_write(16'($urandom), 16'($urandom));
        if ($urandom_range(0, 2) == 0) tick();
      end
      total++;
      if (count !== 4'(q1.size())) begin bad++; $display("FAIL random_count it=%0d got %0d expected %0d", it, count, q1.size()); end
      n = q1.size();
      go = 1'b1; tick(); go = 1'b0;
      for (int k = 0; k <= n + 1; k++) begin
        total++;
        if (obs !== exp_vec(k, n)) begin bad++; $display("FAIL random it=%0d k=%0d got %h expected %h", it, k, obs, exp_vec(k, n)); end
        tick();
      end
      after_done();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_go_empty();
    test_go_with_write();
    test_reset_mid();
    test_replay();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
